beep_seq: RTL
=============

BEEP_SEQ -- requirements
Module: beep_seq

Interface
REQ-001 SHALL have parameter CLK_PER_MS, default 50000, meaning clock cycles per millisecond.
REQ-002 SHALL have parameter ON_MS, default 100, meaning beep-on window length in ms (1..1023).
REQ-003 SHALL have parameter GAP_MS, default 100, meaning silent gap between beeps in ms (1..1023).
REQ-004 SHALL have parameter ALARM_REPS, default 5, meaning beep count of an alarm pattern (1..15).
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_evt  input  1  single-cycle strobe requesting a KEY pattern (1 beep).
REQ-008 lap_evt  input  1  single-cycle strobe requesting a LAP pattern (2 beeps).
REQ-009 alarm_evt  input  1  single-cycle strobe requesting an ALARM pattern (ALARM_REPS beeps).
REQ-010 ack  input  1  level/strobe that aborts any active pattern.
REQ-011 beep  output  1  registered level, high during each on-window; drives the downstream sound stage input.
REQ-012 busy  output  1  registered, high whenever a pattern is active (state not IDLE).
REQ-013 pattern  output  2  registered active pattern code: 0 none, 1 KEY, 2 LAP, 3 ALARM.

Function
REQ-014 SHALL implement states IDLE, ON, GAP.
REQ-015 SHALL contain a prescaler counting 0..CLK_PER_MS-1 that emits a 1 ms tick on terminal count and is cleared on every state entry.
REQ-016 SHALL contain a ms counter, cleared on state entry, incremented on each tick.
REQ-017 SHALL contain a remaining-beeps counter, 4 bits, loaded on pattern start with 1 (KEY), 2 (LAP) or ALARM_REPS (ALARM).
REQ-018 IDLE with any trigger high at an edge SHALL go to ON at that edge; beep, busy and pattern SHALL be valid in the following cycle (latency 1 cycle).
REQ-019 Simultaneous triggers SHALL resolve by priority ALARM > LAP > KEY; lower ones are dropped, not queued.
REQ-020 ON SHALL last exactly ON_MS*CLK_PER_MS cycles with beep=1, then decrement remaining beeps.
REQ-021 On ON exit with remaining beeps (after decrement) nonzero, SHALL enter GAP with beep=0; if zero, SHALL enter IDLE with beep=0, busy=0, pattern=0 in the same cycle.
REQ-022 GAP SHALL last exactly GAP_MS*CLK_PER_MS cycles with beep=0, then return to ON.
REQ-023 A trigger of strictly higher priority than the active pattern SHALL preempt it: restart in ON with counters reloaded for the new pattern; beep SHALL not drop if already in ON.
REQ-024 A trigger of equal or lower priority during an active pattern SHALL be ignored.
REQ-025 ack high at an edge SHALL force IDLE next cycle (beep=0, busy=0, pattern=0), overriding any trigger at the same edge.
REQ-026 beep SHALL never be high in IDLE or GAP; it is glitch-free (flop output only).
REQ-027 Counter widths SHALL be sized from parameters; no counter wraps during a valid pattern.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, beep=0, busy=0, pattern=0 and clear all counters.
REQ-029 Reset asserted mid-pattern SHALL abort it; after release the block SHALL wait in IDLE for a new trigger and SHALL not resume.
REQ-030 Triggers present at the first edge after rst_n release SHALL be accepted normally.

Verification (CLK_PER_MS=10, ON_MS=3, GAP_MS=2, ALARM_REPS=3)
REQ-031 key_evt pulse in IDLE -> beep high 30 cycles starting 1 cycle later, then busy=0, pattern=0.
REQ-032 lap_evt pulse -> beep 30 high, 20 low, 30 high; pattern=2 throughout; busy falls with last beep.
REQ-033 key_evt, lap_evt, alarm_evt same cycle -> pattern=3, three 30-cycle beeps with two 20-cycle gaps.
REQ-034 lap_evt, then alarm_evt 10 cycles later -> beep stays high, pattern becomes 3, ALARM sequence restarts; key_evt during ALARM -> no change.
REQ-035 alarm_evt then ack in second GAP -> beep=0, busy=0, pattern=0 next cycle; ack with key_evt same edge -> stays IDLE.
REQ-036 rst_n low for 2 cycles mid-ON of LAP -> beep=0 immediately (asynchronous); after release no beep until new trigger.

Source files
------------

// File: rtl/beep_seq_if.sv
// beep_seq_if: trigger/ack strobes in, beep/busy/pattern out.
// master drives strobes, slave is the sequencer.
interface beep_seq_if;
  logic       key_evt;
  logic       lap_evt;
  logic       alarm_evt;
  logic       ack;
  logic       beep;
  logic       busy;
  logic [1:0] pattern;

  modport master (
    output key_evt,
    output lap_evt,
    output alarm_evt,
    output ack,
    input  beep,
    input  busy,
    input  pattern
  );

  modport slave (
    input  key_evt,
    input  lap_evt,
    input  alarm_evt,
    input  ack,
    output beep,
    output busy,
    output pattern
  );
endinterface

// File: rtl/beep_seq.sv
// beep_seq: KEY/LAP/ALARM beep pattern sequencer with
// priority preemption, ack abort and ms-based timing.
module beep_seq #(
  parameter int CLK_PER_MS = 50000,
  parameter int ON_MS      = 100,
  parameter int GAP_MS     = 100,
  parameter int ALARM_REPS = 5
) (
  input logic       clk,
  input logic       rst_n,
  beep_seq_if.slave bus
);

  localparam int PRE_W =
    (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int MS_MAX =
    (ON_MS > GAP_MS) ? ON_MS : GAP_MS;
  localparam int MS_W =
    (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(CLK_PER_MS - 1);
  localparam logic [MS_W-1:0] ON_LAST =
    MS_W'(ON_MS - 1);
  localparam logic [MS_W-1:0] GAP_LAST =
    MS_W'(GAP_MS - 1);
  localparam logic [3:0] REPS_ALARM =
    4'(ALARM_REPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PRE_W-1:0] pre_q;
  logic [MS_W-1:0]  ms_q;
  logic [3:0]       reps_q, reps_n, load;
  logic [1:0]       pat_q, pat_n, trig;
  logic             clr, tick;
  logic             beep_q, busy_q;

  // Highest-priority trigger this cycle and its beep count.
  always_comb begin
    trig = 2'd0;
    if (bus.alarm_evt)    trig = 2'd3;
    else if (bus.lap_evt) trig = 2'd2;
    else if (bus.key_evt) trig = 2'd1;
    load = (trig == 2'd3) ? REPS_ALARM
                          : {2'b00, trig};
  end

  // 1 ms tick on prescaler terminal count.
  always_comb begin
    tick = (state != IDLE) && (pre_q == PRE_LAST);
  end

  // Next state; clr marks every state (re)entry.
  always_comb begin
    state_n = state;
    pat_n   = pat_q;
    reps_n  = reps_q;
    clr     = 1'b0;
    if (bus.ack) begin
      state_n = IDLE;
      pat_n   = 2'd0;
      reps_n  = 4'd0;
      clr     = 1'b1;
    end else if (trig > pat_q) begin
      state_n = ON;
      pat_n   = trig;
      reps_n  = load;
      clr     = 1'b1;
    end else begin
      unique case (state)
        ON: begin
          if (tick && ms_q == ON_LAST) begin
            reps_n = reps_q - 4'd1;
            clr    = 1'b1;
            if (reps_q == 4'd1) begin
              state_n = IDLE;
              pat_n   = 2'd0;
            end else begin
              state_n = GAP;
            end
          end
        end
        GAP: begin
          if (tick && ms_q == GAP_LAST) begin
            state_n = ON;
            clr     = 1'b1;
          end
        end
        default: begin
          state_n = state;
        end
      endcase
    end
  end

  // State, pattern and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pat_q  <= 2'd0;
      reps_q <= 4'd0;
      beep_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      pat_q  <= pat_n;
      reps_q <= reps_n;
      beep_q <= (state_n == ON);
      busy_q <= (state_n != IDLE);
    end
  end

  // Prescaler and ms counter, cleared on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (clr || state == IDLE) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (tick) begin
      pre_q <= '0;
      ms_q  <= ms_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  assign bus.beep    = beep_q;
  assign bus.busy    = busy_q;
  assign bus.pattern = pat_q;

endmodule
